cpe_dbuf: RTL
=============

# cpe_dbuf

Parametrised, double-buffered compensation processing element for the systolic array's compensation path. It multiplies an odd-reconstructed signed activation by an odd-reconstructed signed compensation weight and adds the product to the incoming compensation partial sum. A shadow weight register lets the next weight set preload through the chain while the current set keeps computing. An optional saturating accumulator raises a sticky overflow flag.

## Interface
Parameters:
- ACT_W, 7, stored activation bits; the effective activation is {act, 1'b1}, signed, ACT_W+1 bits.
- CW_W, 4, stored compensation-weight bits; the effective weight is {cw, 1'b1}, signed, CW_W+1 bits.
- PSUM_W, 14, partial-sum width; must satisfy PSUM_W >= ACT_W+CW_W+2.
- SAT, 0; 0 = two's-complement wrap, 1 = saturate to the PSUM_W signed range.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous, active-low reset.
- cw_in, input, CW_W, preload weight from the upstream PE.
- cw_in_valid, input, 1, preload-shift strobe.
- cw_out, output, CW_W, shadow register contents, fed to the downstream PE.
- cw_out_valid, output, 1, cw_in_valid delayed by one cycle.
- cw_swap, input, 1, commit shadow to active.
- cw_swap_out, output, 1, cw_swap delayed by one cycle (swap wavefront).
- act_in, input, ACT_W, activation.
- act_valid_in, input, 1, activation valid.
- act_out, output, ACT_W, act_in delayed by one cycle.
- act_valid_out, output, 1, act_valid_in delayed by one cycle.
- psum_in, input, PSUM_W, signed compensation partial sum.
- psum_out, output, PSUM_W, registered result.
- psum_valid_out, output, 1, act_valid_in delayed by one cycle.
- ovf_clr, input, 1, clear the sticky overflow flag.
- ovf, output, 1, sticky overflow flag.

## Operation
- Reset (rst_n=0 at a clk edge) clears:
  - all outputs, shadow, active and active_vld to 0;
  - cw_out=0 and ovf=0 on the following cycle.
- Preload:
  - When cw_in_valid=1: shadow <= cw_in.
  - cw_out is the shadow register contents. A chain of N PEs is filled by N strobes; the first value pushed ends in the farthest PE.
  - When cw_in_valid=0, shadow holds.
- Swap:
  - When cw_swap=1: active <= shadow (the value before any same-cycle preload), and active_vld <= 1.
  - If cw_swap and cw_in_valid are asserted together, both take effect. active receives the old shadow.
- Compute, when act_valid_in=1 and active_vld=1:
  - prod = signed({act_in,1}) × signed({active,1}), ACT_W+CW_W+2 bits, sign-extended to PSUM_W+1 bits.
  - sum = sext(psum_in) + prod, PSUM_W+1 bits.
  - Overflow is detected when sum[PSUM_W] != sum[PSUM_W-1].
  - SAT=0: psum_out <= sum[PSUM_W-1:0].
  - SAT=1: psum_out <= 2^(PSUM_W-1)-1 on positive overflow, or -2^(PSUM_W-1) on negative overflow.
  - Overflow sets ovf in both modes.
- Bypass, when act_valid_in=0 or active_vld=0: psum_out <= psum_in, and ovf is unaffected.
- Preloading never stalls compute. Compute always uses active, never shadow.
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr=1 clears it.
  - Otherwise it holds.

## Timing
- Every output is registered. There is no combinational in-to-out path.
- Latency is 1 cycle for each path:
  - psum_in/act_in to psum_out/psum_valid_out;
  - act_in to act_out;
  - cw_in to the shadow register (visible on cw_out);
  - cw_swap to cw_swap_out.
- A swap at cycle t affects compute from the act_valid_in sampled at cycle t+1 onward. The act_valid_in sampled at cycle t still uses the old active.
- There is no backpressure. A valid pulse is accepted every cycle, giving throughput 1/cycle.
- Reset mid-operation:
  - in-flight results are discarded;
  - psum_valid_out=0 on the next cycle;
  - active_vld=0 until the next swap.

## Test plan
- Reset, then swap with shadow=0, then act_valid_in with psum_in=5, act_in=0:
  - 1·1 is added, so psum_out=6 one cycle later with psum_valid_out=1.
  - Before the swap, the same stimulus gives psum_out=5 (bypass).
- Preload and swap:
  - cw_in=2 is loaded and swapped; then act_in=3, psum_in=100 gives 7×5 added, so psum_out=135.
  - cw_in=4'hF with act_in=7'h7F gives (-1)(-1), so psum_out=psum_in+1.
- Double buffer:
  - With active=2, act_valid_in is held high while cw_in=4'h8 is preloaded. The output continues to use weight 5.
  - A swap is then applied: the next result uses weight -15, so act_in=3, psum_in=0 gives -105.
- Saturation, SAT=1:
  - psum_in=8191, act_in=3, cw=2 gives psum_out=8191 and ovf=1.
  - psum_in=-8192, cw=4'h8, act_in=3 gives psum_out=-8192.
  - ovf_clr then gives ovf=0.
- Wrap, SAT=0: psum_in=8191, act_in=3, cw=2 gives psum_out=-8158 and ovf=1.
- Reset while act_valid_in=1 and in the middle of a preload:
  - psum_valid_out=0 and cw_out=0;
  - subsequent act_valid_in pulses bypass until cw_swap.

Source files
------------

// File: rtl/cpe_dbuf.sv
// ---------------------------------------------------------------------------
// cpe_dbuf
//
// Double-buffered compensation processing element for the systolic array's
// compensation path. Each cycle it can multiply an odd-reconstructed signed
// activation by an odd-reconstructed signed compensation weight and add the
// product to the incoming partial sum. A shadow weight register lets the next
// weight set shift through the PE chain while the active weight keeps
// computing. An optional saturating mode clamps the result, and a sticky flag
// records any overflow.
//
// Parameters
//   ACT_W   stored activation bits; the effective activation is {act,1}
//   CW_W    stored compensation-weight bits; the effective weight is {cw,1}
//   PSUM_W  partial-sum width, at least ACT_W+CW_W+2
//   SAT     0 = two's-complement wrap, 1 = saturate to the signed range
//
// Ports
//   clk            clock
//   rst_n          synchronous active-low reset
//   cw_in          preload weight from the upstream PE
//   cw_in_valid    preload shift strobe
//   cw_out         shadow register contents, to the downstream PE
//   cw_out_valid   cw_in_valid delayed one cycle
//   cw_swap        commit shadow to active
//   cw_swap_out    cw_swap delayed one cycle (swap wavefront)
//   act_in         activation
//   act_valid_in   activation valid
//   act_out        act_in delayed one cycle
//   act_valid_out  act_valid_in delayed one cycle
//   psum_in        signed incoming partial sum
//   psum_out       registered result
//   psum_valid_out act_valid_in delayed one cycle
//   ovf_clr        clear the sticky overflow flag
//   ovf            sticky overflow flag
// ---------------------------------------------------------------------------
module cpe_dbuf #(
   parameter int ACT_W  = 7,
   parameter int CW_W   = 4,
   parameter int PSUM_W = 14,
   parameter int SAT    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CW_W-1:0]   cw_in,
   input  logic              cw_in_valid,
   output logic [CW_W-1:0]   cw_out,
   output logic              cw_out_valid,
   input  logic              cw_swap,
   output logic              cw_swap_out,
   input  logic [ACT_W-1:0]  act_in,
   input  logic              act_valid_in,
   output logic [ACT_W-1:0]  act_out,
   output logic              act_valid_out,
   input  logic [PSUM_W-1:0] psum_in,
   output logic [PSUM_W-1:0] psum_out,
   output logic              psum_valid_out,
   input  logic              ovf_clr,
   output logic              ovf
);

   localparam int PROD_W = ACT_W + CW_W + 2;

   // Weight storage: shadow is the preload chain stage, active feeds the
   // multiplier. activeVld stays low until the first swap after reset so the
   // PE bypasses rather than computing with an uncommitted weight.
   logic [CW_W-1:0]   r_shadow;
   logic [CW_W-1:0]   r_active;
   logic              r_activeVld;

   // Pipeline registers that drive the outputs directly.
   logic              r_cwOutValid;
   logic              r_swapOut;
   logic [ACT_W-1:0]  r_actOut;
   logic              r_actValidOut;
   logic [PSUM_W-1:0] r_psum;
   logic              r_psumValid;
   logic              r_ovf;

   // Datapath wires.
   logic signed [PROD_W-1:0] w_actEff;
   logic signed [PROD_W-1:0] w_cwEff;
   logic signed [PROD_W-1:0] w_prod;
   logic        [PSUM_W:0]   w_sum;
   logic                     w_compute;
   logic                     w_sumOvf;
   logic        [PSUM_W-1:0] w_result;

   // Odd reconstruction appends a constant 1 LSB, so the stored code c stands
   // for the odd value 2c+1. Both operands are sign-extended to the full
   // product width first so the signed multiply is exact and width-matched.
   always_comb begin
      w_actEff = {{(PROD_W-ACT_W-1){act_in[ACT_W-1]}}, act_in, 1'b1};
      w_cwEff  = {{(PROD_W-CW_W-1){r_active[CW_W-1]}}, r_active, 1'b1};
      w_prod   = w_actEff * w_cwEff;
   end

   // The sum is formed one bit wider than the partial sum, so an overflow out
   // of PSUM_W bits shows up as the top two bits disagreeing. The top bit
   // itself gives the true sign and therefore the saturation direction.
   always_comb begin
      w_compute = act_valid_in & r_activeVld;
      w_sum     = {{(PSUM_W+1-PROD_W){w_prod[PROD_W-1]}}, w_prod}
                + {psum_in[PSUM_W-1], psum_in};
      w_sumOvf  = w_sum[PSUM_W] ^ w_sum[PSUM_W-1];
      w_result  = w_sum[PSUM_W-1:0];
      if ((SAT != 0) && w_sumOvf) begin
         if (w_sum[PSUM_W]) begin
            w_result = {1'b1, {(PSUM_W-1){1'b0}}};
         end else begin
            w_result = {1'b0, {(PSUM_W-1){1'b1}}};
         end
      end
   end

   // Weight preload and swap. A swap in the same cycle as a preload commits
   // the shadow value from before the preload, because both sides read the
   // register's current contents at the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shadow     <= '0;
         r_active     <= '0;
         r_activeVld  <= 1'b0;
         r_cwOutValid <= 1'b0;
         r_swapOut    <= 1'b0;
      end else begin
         if (cw_in_valid) begin
            r_shadow <= cw_in;
         end
         if (cw_swap) begin
            r_active    <= r_shadow;
            r_activeVld <= 1'b1;
         end
         r_cwOutValid <= cw_in_valid;
         r_swapOut    <= cw_swap;
      end
   end

   // Activation and partial-sum pipeline. Without a valid activation and a
   // committed weight the partial sum passes through unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_actOut      <= '0;
         r_actValidOut <= 1'b0;
         r_psum        <= '0;
         r_psumValid   <= 1'b0;
      end else begin
         r_actOut      <= act_in;
         r_actValidOut <= act_valid_in;
         r_psumValid   <= act_valid_in;
         if (w_compute) begin
            r_psum <= w_result;
         end else begin
            r_psum <= psum_in;
         end
      end
   end

   // Sticky overflow: a new overflow wins over a clear in the same cycle so
   // an event is never lost to a coincident clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_compute && w_sumOvf) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign cw_out         = r_shadow;
   assign cw_out_valid   = r_cwOutValid;
   assign cw_swap_out    = r_swapOut;
   assign act_out        = r_actOut;
   assign act_valid_out  = r_actValidOut;
   assign psum_out       = r_psum;
   assign psum_valid_out = r_psumValid;
   assign ovf            = r_ovf;

endmodule
